// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arbState_e : arbiter FSM states (idle, memory access, response)
//   REQ_CORE   : requester id of the core load/store unit (port r0)
//   REQ_LOADER : requester id of the loader/debug port (port r1)
// Arbitration policy is selected by the macro DMEM_ARB_ROUND_ROBIN_EN
// (defined: round robin, undefined: fixed priority to r0).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arbState_e;

  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port DMEM.
//   r0_* / r1_*  : request handshake (valid/ready/we/addr/wdata) and response
//                  (rsp_valid pulse, rsp_rdata) per requester
//   mem_*        : single-port DMEM control; mem_rdata is combinational for mem_addr
//   busy, gnt_id : arbiter status (not idle, owner of current transaction)
// Modports: slave = arbiter side, master = requester/memory side.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);

  logic              r0_valid;
  logic              r0_ready;
  logic              r0_we;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_rsp_valid;
  logic [DATA_W-1:0] r0_rsp_rdata;

  logic              r1_valid;
  logic              r1_ready;
  logic              r1_we;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_rsp_valid;
  logic [DATA_W-1:0] r1_rsp_rdata;

  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              gnt_id;

  modport slave (
    input  r0_valid, r0_we, r0_addr, r0_wdata,
    output r0_ready, r0_rsp_valid, r0_rsp_rdata,
    input  r1_valid, r1_we, r1_addr, r1_wdata,
    output r1_ready, r1_rsp_valid, r1_rsp_rdata,
    output mem_we, mem_re, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, gnt_id
  );

  modport master (
    output r0_valid, r0_we, r0_addr, r0_wdata,
    input  r0_ready, r0_rsp_valid, r0_rsp_rdata,
    output r1_valid, r1_we, r1_addr, r1_wdata,
    input  r1_ready, r1_rsp_valid, r1_rsp_rdata,
    input  mem_we, mem_re, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, gnt_id
  );

endinterface

// File: rtl/dmem_arb_grant.sv
// Two-requester grant logic, purely combinational.
//   lastGnt : id of the requester granted last (only with DMEM_ARB_ROUND_ROBIN_EN)
//   valid   : request valid, bit 0 = r0 (core), bit 1 = r1 (loader)
//   gnt     : one-hot grant, zero when nothing is valid
// DMEM_ARB_ROUND_ROBIN_EN defined: contention goes to the requester not granted
// last. Undefined: r0 always wins contention.
module dmem_arb_grant
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  logic       lastGnt,
`endif
  input  logic [1:0] valid,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = valid;
    if (valid == 2'b11) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      gnt = (lastGnt == REQ_CORE) ? 2'b10 : 2'b01;
`else
      gnt = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates two requesters onto one single-port data memory, one outstanding
// transaction at a time: accept -> ACCESS (one memory cycle) -> RESP (response
// pulse, may accept the next request). Read latency is 2 cycles.
// Ports:
//   CLK   : clock, all state on posedge
//   reset : synchronous active-high reset; aborts any transaction in flight
//   bus   : dmem_arbiter_if.slave (requester handshakes, DMEM control, status)
// Macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration (default:
// fixed priority to r0).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input logic           CLK,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  arbState_e         stateQ, stateD;
  logic              weQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [DATA_W-1:0] rdataQ;
  logic              idQ;

  logic [1:0]        gnt;
  logic              canAccept;
  logic              accept;
  logic              acceptId;
  logic              inAccess;
  logic              rspFire;

  // Request of the winner, muxed for latching.
  logic              reqWe;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic lastGntQ;
`endif

  dmem_arb_grant uGrant (
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    .lastGnt (lastGntQ),
`endif
    .valid   ({bus.r1_valid, bus.r0_valid}),
    .gnt     (gnt)
  );

  // Arbitration points are IDLE and RESP; reset blocks any accept.
  assign canAccept = !reset && ((stateQ == StIdle) || (stateQ == StResp));
  assign accept    = canAccept && (gnt != 2'b00);
  assign acceptId  = gnt[1];

  assign bus.r0_ready = canAccept && gnt[0];
  assign bus.r1_ready = canAccept && gnt[1];

  assign reqWe    = acceptId ? bus.r1_we    : bus.r0_we;
  assign reqAddr  = acceptId ? bus.r1_addr  : bus.r0_addr;
  assign reqWdata = acceptId ? bus.r1_wdata : bus.r0_wdata;

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:   if (accept) stateD = StAccess;
      StAccess: stateD = StResp;
      StResp:   stateD = accept ? StAccess : StIdle;
      default:  stateD = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      weQ    <= 1'b0;
      addrQ  <= '0;
      wdataQ <= '0;
      idQ    <= REQ_CORE;
      rdataQ <= '0;
    end else begin
      if (accept) begin
        weQ    <= reqWe;
        addrQ  <= reqAddr;
        wdataQ <= reqWdata;
        idQ    <= acceptId;
      end
      if (stateQ == StAccess) begin
        rdataQ <= weQ ? '0 : bus.mem_rdata;
      end
    end
  end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // Starts as "loader granted last" so the first contention goes to r0.
  always_ff @(posedge CLK) begin
    if (reset) begin
      lastGntQ <= REQ_LOADER;
    end else if (accept) begin
      lastGntQ <= acceptId;
    end
  end
`endif

  // Gated by reset so an abort in ACCESS never writes memory on that edge.
  assign inAccess = (stateQ == StAccess) && !reset;
  assign rspFire  = (stateQ == StResp) && !reset;

  // Address/data come straight from the latches, so they hold between accesses.
  assign bus.mem_we    = inAccess && weQ;
  assign bus.mem_re    = inAccess && !weQ;
  assign bus.mem_addr  = addrQ;
  assign bus.mem_wdata = wdataQ;

  assign bus.r0_rsp_valid = rspFire && (idQ == REQ_CORE);
  assign bus.r1_rsp_valid = rspFire && (idQ == REQ_LOADER);
  assign bus.r0_rsp_rdata = (idQ == REQ_CORE)   ? rdataQ : '0;
  assign bus.r1_rsp_rdata = (idQ == REQ_LOADER) ? rdataQ : '0;

  assign bus.busy   = (stateQ != StIdle);
  assign bus.gnt_id = idQ;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural single-port DMEM.
// Responses are checked by a scoreboard monitor (owner, data, 2-cycle latency).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          memAcc = 0;
  logic [31:0] mem [1024];

  assign bus.mem_rdata = mem[bus.mem_addr];

  // Memory preset to 0xA5000000 | address; written on posedge when mem_we.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    forever begin
      @(posedge CLK);
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (bus.mem_we || bus.mem_re) memAcc++;
      if (!reset) chk("ready_exclusive", 32'(bus.r0_ready & bus.r1_ready), 32'd0);
      if (bus.r0_rsp_valid || bus.r1_rsp_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: actual r0=%b r1=%b required none",
                   bus.r0_rsp_valid, bus.r1_rsp_valid);
        end else begin
          e = sbq.pop_front();
          chk("rsp_owner", {30'd0, bus.r1_rsp_valid, bus.r0_rsp_valid},
              e.id ? 32'd2 : 32'd1);
          chk("rsp_rdata", e.id ? bus.r1_rsp_rdata : bus.r0_rsp_rdata, e.rdata);
          chk("rsp_latency", cyc, e.cyc + 2);
        end
      end
    end
  end

  task automatic setReq(input logic id, input logic v, input logic we,
                        input logic [AW-1:0] a, input logic [31:0] d);
    if (!id) begin
      bus.r0_valid = v; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
    end else begin
      bus.r1_valid = v; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
    end
  endtask

  function automatic logic readyOf(input logic id);
    return id ? bus.r1_ready : bus.r0_ready;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Call at posedge+1. Holds valid until accepted; returns at posedge+1 of ACCESS.
  task automatic issue(input logic id, input logic we, input logic [AW-1:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, output int accCyc);
    bit done = 0;
    accCyc = -1;
    setReq(id, 1'b1, we, a, wd);
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge CLK);
      if (readyOf(id)) begin
        done = 1;
        accCyc = cyc;
        sbq.push_back('{id, we ? 32'd0 : rd, cyc});
      end
      @(posedge CLK);
      #1;
    end
    setReq(id, 1'b0, 1'b0, '0, '0);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual no ready for r%0d required accept", id);
    end
  endtask

  // Uncontended transfer with memory-side checks in ACCESS and RESP.
  task automatic xfer(input logic id, input logic we, input logic [AW-1:0] a,
                      input logic [31:0] wd, input logic [31:0] rd);
    int acc;
    issue(id, we, a, wd, rd, acc);
    if (acc >= 0) begin
      @(negedge CLK);
      chk("acc_mem_we", 32'(bus.mem_we), 32'(we));
      chk("acc_mem_re", 32'(bus.mem_re), 32'(!we));
      chk("acc_mem_addr", 32'(bus.mem_addr), 32'(a));
      if (we) chk("acc_mem_wdata", bus.mem_wdata, wd);
      chk("acc_gnt_id", 32'(bus.gnt_id), 32'(id));
      chk("acc_busy", 32'(bus.busy), 32'd1);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("resp_mem_idle", 32'(bus.mem_we | bus.mem_re), 32'd0);
      chk("resp_addr_hold", 32'(bus.mem_addr), 32'(a));
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic doReset();
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    int a0, a1, k, m0;
    logic expId;

    // Reset with both requesters valid: no ready, all outputs quiet.
    reset = 1'b1;
    setReq(1'b0, 1'b1, 1'b0, 10'd1, 32'd0);
    setReq(1'b1, 1'b1, 1'b0, 10'd2, 32'd0);
    idle(3);
    @(negedge CLK);
    chk("rst_r0_ready", 32'(bus.r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(bus.r1_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_mem_ctl", 32'(bus.mem_we | bus.mem_re), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rsp", 32'(bus.r0_rsp_valid | bus.r1_rsp_valid), 32'd0);
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge CLK);
    #1;
    reset = 1'b0;

    // Core write then read back of address 5.
    xfer(1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF, 32'd0);
    xfer(1'b0, 1'b0, 10'd5, 32'd0, 32'hDEAD_BEEF);

    // Simultaneous reads: r0 first, r1 accepted in r0's RESP cycle.
    doReset();
    fork
      issue(1'b0, 1'b0, 10'd8, 32'd0, 32'hA500_0008, a0);
      issue(1'b1, 1'b0, 10'd9, 32'd0, 32'hA500_0009, a1);
    join
    chk("contend_r1_accept_cycle", a1, a0 + 2);

    // Both continuously valid for 8 accepts.
    setReq(1'b0, 1'b1, 1'b0, 10'd16, 32'd0);
    setReq(1'b1, 1'b1, 1'b0, 10'd17, 32'd0);
    k = 0;
    for (int c = 0; c < 40 && k < 8; c++) begin
      @(negedge CLK);
      if (bus.r0_ready || bus.r1_ready) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        expId = (k % 2) == 1;
`else
        expId = 1'b0;
`endif
        chk("grant_seq", {30'd0, bus.r1_ready, bus.r0_ready}, expId ? 32'd2 : 32'd1);
        sbq.push_back('{expId, expId ? 32'hA500_0011 : 32'hA500_0010, cyc});
        k++;
      end
      @(posedge CLK);
      #1;
    end
    setReq(1'b0, 1'b0, 1'b0, '0, '0);
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    chk("grant_count", k, 8);
    idle(3);

    // r1 write to 0x3FF aborted by reset in ACCESS.
    setReq(1'b1, 1'b1, 1'b1, 10'h3FF, 32'h0000_1234);
    @(negedge CLK);
    chk("abort_accept_ready", 32'(bus.r1_ready), 32'd1);
    @(posedge CLK);
    #1;
    reset = 1'b1;
    @(negedge CLK);
    chk("abort_no_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_ready_in_reset", 32'(bus.r1_ready), 32'd0);
    @(posedge CLK);
    #1;
    reset = 1'b0;
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    chk("abort_idle", 32'(bus.busy), 32'd0);
    chk("abort_no_rsp", 32'(bus.r1_rsp_valid), 32'd0);
    @(posedge CLK);
    #1;
    xfer(1'b1, 1'b0, 10'h3FF, 32'd0, 32'hA500_03FF);

    // r1 pulsed only during r0's ACCESS: never accepted, no extra access.
    issue(1'b0, 1'b1, 10'd20, 32'h55AA_55AA, 32'd0, a0);
    m0 = memAcc;
    setReq(1'b1, 1'b1, 1'b1, 10'd21, 32'hFFFF_FFFF);
    @(negedge CLK);
    chk("pulse_r1_ready", 32'(bus.r1_ready), 32'd0);
    chk("pulse_mem_addr", 32'(bus.mem_addr), 32'd20);
    @(posedge CLK);
    #1;
    setReq(1'b1, 1'b0, 1'b0, '0, '0);
    idle(6);
    chk("pulse_mem_access_count", memAcc - m0, 1);
    xfer(1'b0, 1'b0, 10'd20, 32'd0, 32'h55AA_55AA);
    xfer(1'b1, 1'b0, 10'd21, 32'd0, 32'hA500_0015);

    for (int c = 0; c < 20 && sbq.size() != 0; c++) @(posedge CLK);
    chk("sb_drain", sbq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
